// File: rtl/game_sequencer.sv
// game_sequencer: HOME/FACE/player-attack/monster-attack/OVER game flow with HP bookkeeping.
// Define INVULN_EN to ignore further hits for INVULN_TICKS cycles after each applied hit.
module game_sequencer #(
    parameter int TICKS_PER_SEC  = 100000000,
    parameter int ATTACK_SECONDS = 6,
    parameter int PLAYER_HP      = 300,
    parameter int MONSTER_HP     = 500,
    parameter int DMG1           = 10,
    parameter int DMG2           = 25,
    parameter int DMG3           = 50,
    parameter int HIT_DAMAGE     = 20,
    parameter int INVULN_TICKS   = 50000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enter_key,
    input  logic        i_bar_stop,
    input  logic [1:0]  i_bar_score,
    input  logic        i_hit,
    output logic [2:0]  o_state,
    output logic        o_bar_active,
    output logic        o_attack_active,
    output logic [15:0] o_player_hp,
    output logic [15:0] o_monster_hp,
    output logic        o_win
);
    localparam int PW = $clog2(TICKS_PER_SEC + 1);
    localparam int SW = $clog2(ATTACK_SECONDS + 1);
    typedef enum logic [2:0] {HOME = 3'd0, FACE = 3'd1, P_ATK = 3'd2, M_ATK = 3'd3, OVER = 3'd4} state_t;
    state_t state, nxt;
    logic [PW-1:0] pre;
    logic [SW-1:0] sec;
    logic hit_q, hit_ok, tick, timeout;
    logic [15:0] dmg, m_hp, p_hp;
`ifdef INVULN_EN
    localparam int IW = $clog2(INVULN_TICKS + 1);
    logic [IW-1:0] inv;
    assign hit_ok = state == M_ATK && i_hit && !hit_q && inv == '0;
`else
    assign hit_ok = state == M_ATK && i_hit && !hit_q;
`endif
    assign tick    = pre == PW'(TICKS_PER_SEC - 1);
    assign timeout = tick && sec == SW'(ATTACK_SECONDS - 1);
    assign dmg     = i_bar_score == 2'd3 ? 16'(DMG3) : i_bar_score == 2'd2 ? 16'(DMG2) :
                     i_bar_score == 2'd1 ? 16'(DMG1) : 16'd0;
    assign m_hp    = o_monster_hp > dmg ? o_monster_hp - dmg : 16'd0;
    assign p_hp    = o_player_hp > 16'(HIT_DAMAGE) ? o_player_hp - 16'(HIT_DAMAGE) : 16'd0;
    assign o_state = state;
    // A hit landing on the timeout edge is applied first, so death beats FACE
    always_comb begin
        nxt = state;
        case (state)
            HOME:    nxt = i_enter_key ? FACE : HOME;
            FACE:    nxt = i_enter_key ? P_ATK : FACE;
            P_ATK:   nxt = !i_bar_stop ? P_ATK : m_hp == 16'd0 ? OVER : M_ATK;
            M_ATK:   nxt = hit_ok && p_hp == 16'd0 ? OVER : timeout ? FACE : M_ATK;
            OVER:    nxt = i_enter_key ? HOME : OVER;
            default: nxt = HOME;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= HOME;
            o_bar_active    <= 1'b0;
            o_attack_active <= 1'b0;
            o_win           <= 1'b0;
            o_player_hp     <= 16'(PLAYER_HP);
            o_monster_hp    <= 16'(MONSTER_HP);
            pre             <= '0;
            sec             <= '0;
            hit_q           <= 1'b0;
`ifdef INVULN_EN
            inv             <= '0;
`endif
        end else begin
            state           <= nxt;
            o_bar_active    <= nxt == P_ATK;
            o_attack_active <= nxt == M_ATK;
            hit_q           <= i_hit;
            if (state == HOME && i_enter_key) begin
                o_player_hp  <= 16'(PLAYER_HP);
                o_monster_hp <= 16'(MONSTER_HP);
                o_win        <= 1'b0;
            end
            if (state == P_ATK && i_bar_stop) begin
                o_monster_hp <= m_hp;
                o_win        <= m_hp == 16'd0;
            end
            if (hit_ok) begin
                o_player_hp <= p_hp;
                if (p_hp == 16'd0) o_win <= 1'b0;
            end
            // Counters run only while staying in M_ATK; any entry or exit clears them
            if (state == M_ATK && nxt == M_ATK) begin
                pre <= tick ? '0 : pre + PW'(1);
                sec <= sec + SW'(tick);
            end else begin
                pre <= '0;
                sec <= '0;
            end
`ifdef INVULN_EN
            if (nxt != M_ATK) inv <= '0;
            else if (hit_ok) inv <= IW'(INVULN_TICKS);
            else if (inv != '0) inv <= inv - IW'(1);
`endif
        end
    end
endmodule
